// File: rtl/fme_satd_ctrl_pkg.sv
// Shared types and constants for the FME SATD sequencing controller.
// Block-height helpers map the 2-bit height code to row and 4x4 counts.
package fme_satd_ctrl_pkg;

  localparam int SATD_BLK_BITS = 16;

  localparam logic [1:0] FME_BLK_H4  = 2'd0;
  localparam logic [1:0] FME_BLK_H8  = 2'd1;
  localparam logic [1:0] FME_BLK_H16 = 2'd2;

  typedef enum logic [2:0] {
    FME_SC_IDLE = 3'd0,
    FME_SC_FEED = 3'd1,
    FME_SC_WAIT = 3'd2,
    FME_SC_CLR  = 3'd3,
    FME_SC_DONE = 3'd4
  } fme_sc_state_e;

  // The reserved code 3 behaves as a 16-row block.
  function automatic logic [3:0] blk_h_last(input logic [1:0] h);
    case (h)
      FME_BLK_H4: return 4'd3;
      FME_BLK_H8: return 4'd7;
      default:    return 4'd15;
    endcase
  endfunction

  function automatic logic [2:0] blk_h_n4(input logic [1:0] h);
    case (h)
      FME_BLK_H4: return 3'd1;
      FME_BLK_H8: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/fme_satd_best.sv
// Tracks the minimum block SATD and its candidate index; updates on load_i.
// Single-cycle register update, no backpressure; ties keep the earlier index.
module fme_satd_best
  import fme_satd_ctrl_pkg::*;
#(
  parameter int CAND_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_i,
  input  logic                     is_first_i,
  input  logic [SATD_BLK_BITS-1:0] cost_i,
  input  logic [CAND_W-1:0]        idx_i,
  output logic [SATD_BLK_BITS-1:0] best_satd_o,
  output logic [CAND_W-1:0]        best_idx_o
);

  logic [SATD_BLK_BITS-1:0] best_satd_q, best_satd_d;
  logic [CAND_W-1:0]        best_idx_q, best_idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_satd_q <= '0;
      best_idx_q  <= '0;
    end else begin
      best_satd_q <= best_satd_d;
      best_idx_q  <= best_idx_d;
    end
  end

  always_comb begin
    best_satd_d = best_satd_q;
    best_idx_d  = best_idx_q;
    if (load_i && (is_first_i || (cost_i < best_satd_q))) begin
      best_satd_d = cost_i;
      best_idx_d  = idx_i;
    end
  end

  assign best_satd_o = best_satd_q;
  assign best_idx_o  = best_idx_q;

endmodule

// File: rtl/fme_satd_ctrl.sv
// Sequences row strobes and block-end clears for the dual 4xN SATD datapath per candidate.
// Waits on the datapath's 4x4 pulses rather than a fixed latency; start_i ignored while busy.
module fme_satd_ctrl
  import fme_satd_ctrl_pkg::*;
#(
  parameter int CAND_NUM = 8,
  parameter int CAND_W   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [1:0]               blk_h_i,
  output logic                     busy_o,
  output logic                     row_valid_o,
  output logic [3:0]               row_idx_o,
  output logic [CAND_W-1:0]        cand_idx_o,
  input  logic                     satd_4x4_valid_i,
  output logic                     satd_blk_valid_o,
  input  logic [SATD_BLK_BITS-2:0] hd0_satd_4xn_i,
  input  logic [SATD_BLK_BITS-2:0] hd1_satd_4xn_i,
  output logic [SATD_BLK_BITS-1:0] best_satd_o,
  output logic [CAND_W-1:0]        best_idx_o,
  output logic                     done_o
);

  localparam logic [CAND_W-1:0] CAND_LAST = CAND_W'(CAND_NUM - 1);

  fme_sc_state_e state_q, state_d;
  logic [1:0]        blk_h_q, blk_h_d;
  logic [3:0]        row_q, row_d;
  logic [2:0]        blk4_q, blk4_d;
  logic [CAND_W-1:0] cand_q, cand_d;

  logic [3:0]               h_last;
  logic [2:0]               n4;
  logic [SATD_BLK_BITS-1:0] cost;
  logic                     best_load;
  logic                     best_first;

  assign h_last = blk_h_last(blk_h_q);
  assign n4     = blk_h_n4(blk_h_q);
  assign cost   = SATD_BLK_BITS'(hd0_satd_4xn_i) + SATD_BLK_BITS'(hd1_satd_4xn_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FME_SC_IDLE;
      blk_h_q <= '0;
      row_q   <= '0;
      blk4_q  <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_h_q <= blk_h_d;
      row_q   <= row_d;
      blk4_q  <= blk4_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_h_d = blk_h_q;
    row_d   = row_q;
    blk4_d  = blk4_q;
    cand_d  = cand_q;

    // Saturate at H/4 so late or duplicate pulses cannot push past completion.
    if (((state_q == FME_SC_FEED) || (state_q == FME_SC_WAIT)) &&
        satd_4x4_valid_i && (blk4_q != n4)) begin
      blk4_d = blk4_q + 3'd1;
    end

    case (state_q)
      FME_SC_IDLE: begin
        if (start_i) begin
          state_d = FME_SC_FEED;
          blk_h_d = blk_h_i;
          row_d   = '0;
          blk4_d  = '0;
          cand_d  = '0;
        end
      end
      FME_SC_FEED: begin
        if (row_q == h_last) begin
          state_d = FME_SC_WAIT;
          row_d   = '0;
        end else begin
          row_d = row_q + 4'd1;
        end
      end
      FME_SC_WAIT: begin
        if (blk4_q == n4) state_d = FME_SC_CLR;
      end
      FME_SC_CLR: begin
        if (cand_q != CAND_LAST) begin
          state_d = FME_SC_FEED;
          cand_d  = cand_q + 1'b1;
          row_d   = '0;
          blk4_d  = '0;
        end else begin
          state_d = FME_SC_DONE;
        end
      end
      FME_SC_DONE: state_d = FME_SC_IDLE;
      default:     state_d = FME_SC_IDLE;
    endcase
  end

  always_comb begin
    busy_o           = (state_q != FME_SC_IDLE);
    row_valid_o      = (state_q == FME_SC_FEED);
    row_idx_o        = (state_q == FME_SC_FEED) ? row_q : 4'd0;
    satd_blk_valid_o = (state_q == FME_SC_CLR);
    done_o           = (state_q == FME_SC_DONE);
    best_load        = (state_q == FME_SC_CLR);
    best_first       = (cand_q == '0);
  end

  assign cand_idx_o = cand_q;

  fme_satd_best #(
    .CAND_W(CAND_W)
  ) u_best (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (best_load),
    .is_first_i  (best_first),
    .cost_i      (cost),
    .idx_i       (cand_q),
    .best_satd_o (best_satd_o),
    .best_idx_o  (best_idx_o)
  );

endmodule

// File: tb/tb_fme_satd_ctrl.sv
// Directed bench for fme_satd_ctrl with a latency-3 datapath pulse model.
module tb_fme_satd_ctrl;
  import fme_satd_ctrl_pkg::*;

  localparam int CAND_NUM = 8;
  localparam int CAND_W   = 4;
  localparam int SB       = SATD_BLK_BITS;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    blk_h_i = 2'd0;
  logic          busy_o, row_valid_o, satd_blk_valid_o, done_o;
  logic [3:0]    row_idx_o;
  logic [CAND_W-1:0] cand_idx_o, best_idx_o;
  logic          satd_4x4_valid_i;
  logic [SB-2:0] hd0_satd_4xn_i, hd1_satd_4xn_i;
  logic [SB-1:0] best_satd_o;

  logic [SB-2:0] lane_tbl [CAND_NUM];
  logic [2:0]    pipe = '0;
  logic          extra_q = 1'b0;
  logic          dbl_en = 1'b0;
  logic          spur = 1'b0;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, cur_h = 4, exp_row = 0;
  int n_row = 0, row_err = 0, n_p4 = 0, last_p4 = 0, n_blk = 0, gap_err = 0, n_done = 0;
  int cand_seq [$];

  always #5 clk_i = ~clk_i;

  fme_satd_ctrl #(.CAND_NUM(CAND_NUM), .CAND_W(CAND_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .blk_h_i          (blk_h_i),
    .busy_o           (busy_o),
    .row_valid_o      (row_valid_o),
    .row_idx_o        (row_idx_o),
    .cand_idx_o       (cand_idx_o),
    .satd_4x4_valid_i (satd_4x4_valid_i),
    .satd_blk_valid_o (satd_blk_valid_o),
    .hd0_satd_4xn_i   (hd0_satd_4xn_i),
    .hd1_satd_4xn_i   (hd1_satd_4xn_i),
    .best_satd_o      (best_satd_o),
    .best_idx_o       (best_idx_o),
    .done_o           (done_o)
  );

  // Datapath model: a 4x4 pulse three cycles after every fourth row strobe.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_i) begin
      pipe    <= '0;
      extra_q <= 1'b0;
    end else begin
      pipe    <= {pipe[1:0], row_valid_o && (row_idx_o[1:0] == 2'd3)};
      extra_q <= pipe[2] & dbl_en;
    end
  end

  assign satd_4x4_valid_i = pipe[2] | extra_q | spur;
  assign hd0_satd_4xn_i   = lane_tbl[cand_idx_o[2:0]];
  assign hd1_satd_4xn_i   = lane_tbl[cand_idx_o[2:0]];

  always @(negedge clk_i) begin
    if (row_valid_o) begin
      n_row = n_row + 1;
      if (int'(row_idx_o) != exp_row) row_err = row_err + 1;
      exp_row = (exp_row == cur_h - 1) ? 0 : exp_row + 1;
    end
    if (pipe[2]) begin
      n_p4 = n_p4 + 1;
      last_p4 = cyc;
    end
    if (satd_blk_valid_o) begin
      n_blk = n_blk + 1;
      if (cyc - last_p4 != 2) gap_err = gap_err + 1;
      cand_seq.push_back(int'(cand_idx_o));
    end
    if (done_o) n_done = n_done + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_mon(input int h);
    cur_h = h; exp_row = 0; n_row = 0; row_err = 0; n_p4 = 0;
    n_blk = 0; gap_err = 0; n_done = 0;
    cand_seq.delete();
  endtask

  task automatic set_lanes(input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7);
    lane_tbl[0] = (SB-1)'(v0); lane_tbl[1] = (SB-1)'(v1);
    lane_tbl[2] = (SB-1)'(v2); lane_tbl[3] = (SB-1)'(v3);
    lane_tbl[4] = (SB-1)'(v4); lane_tbl[5] = (SB-1)'(v5);
    lane_tbl[6] = (SB-1)'(v6); lane_tbl[7] = (SB-1)'(v7);
  endtask

  // Runs one start-to-done pass; poke re-asserts start mid-run and in the DONE cycle.
  task automatic run_pass(input string tag, input logic [1:0] h, input int hval, input bit poke);
    bit seen;
    seen = 1'b0;
    clear_mon(hval);
    @(negedge clk_i);
    blk_h_i = h;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      start_i = poke && (i == 20 || i == 21);
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    start_i = 1'b0;
    check_eq({tag, "_done_seen"}, int'(seen), 1);
    if (poke && seen) begin
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      check_eq({tag, "_start_in_done_ignored"}, int'(busy_o), 0);
    end
    repeat (6) @(negedge clk_i);
    check_eq({tag, "_done_count"}, n_done, 1);
  endtask

  initial begin
    set_lanes(50, 40, 60, 40, 70, 90, 30, 30);
    repeat (3) @(negedge clk_i);
    check_eq("rst_busy", int'(busy_o), 0);
    check_eq("rst_row_valid", int'(row_valid_o), 0);
    check_eq("rst_blk_valid", int'(satd_blk_valid_o), 0);
    check_eq("rst_done", int'(done_o), 0);
    check_eq("rst_best_satd", int'(best_satd_o), 0);
    check_eq("rst_best_idx", int'(best_idx_o), 0);
    check_eq("rst_cand_idx", int'(cand_idx_o), 0);
    rst_i = 1'b0;

    // H=4: costs 100,80,120,80,140,180,60,60 -> 60 at index 6 (tie keeps 6)
    run_pass("h4", FME_BLK_H4, 4, 1'b0);
    check_eq("h4_rows", n_row, 32);
    check_eq("h4_row_idx_err", row_err, 0);
    check_eq("h4_blk_valid", n_blk, 8);
    check_eq("h4_clr_gap_err", gap_err, 0);
    check_eq("h4_best_satd", int'(best_satd_o), 60);
    check_eq("h4_best_idx", int'(best_idx_o), 6);

    // H=16, all costs 100
    set_lanes(50, 50, 50, 50, 50, 50, 50, 50);
    run_pass("h16", FME_BLK_H16, 16, 1'b0);
    check_eq("h16_rows", n_row, 128);
    check_eq("h16_row_idx_err", row_err, 0);
    check_eq("h16_4x4_pulses", n_p4, 32);
    check_eq("h16_blk_valid", n_blk, 8);
    check_eq("h16_clr_gap_err", gap_err, 0);
    check_eq("h16_best_satd", int'(best_satd_o), 100);
    check_eq("h16_best_idx", int'(best_idx_o), 0);

    // Max lane values: 32767 + 32767 = 65534, no wrap
    set_lanes(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
    run_pass("max", FME_BLK_H8, 8, 1'b0);
    check_eq("max_rows", n_row, 64);
    check_eq("max_best_satd", int'(best_satd_o), 65534);
    check_eq("max_best_idx", int'(best_idx_o), 0);

    // start_i during busy and in DONE
    set_lanes(50, 40, 60, 40, 70, 90, 30, 30);
    run_pass("poke", FME_BLK_H8, 8, 1'b1);
    check_eq("poke_blk_valid", n_blk, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cand_seq.size()) check_eq($sformatf("poke_cand_seq%0d", i), cand_seq[i], i);
    end
    check_eq("poke_best_satd", int'(best_satd_o), 60);
    check_eq("poke_best_idx", int'(best_idx_o), 6);

    // Reset in WAIT of candidate 3
    clear_mon(4);
    @(negedge clk_i);
    blk_h_i = FME_BLK_H4;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if (busy_o && cand_idx_o == 4'd3 && !row_valid_o && !satd_blk_valid_o) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk_i);
      end
      check_eq("rstmid_reached_wait3", int'(hit), 1);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("rstmid_busy", int'(busy_o), 0);
    check_eq("rstmid_row_valid", int'(row_valid_o), 0);
    check_eq("rstmid_row_idx", int'(row_idx_o), 0);
    check_eq("rstmid_cand_idx", int'(cand_idx_o), 0);
    check_eq("rstmid_blk_valid", int'(satd_blk_valid_o), 0);
    check_eq("rstmid_best_satd", int'(best_satd_o), 0);
    check_eq("rstmid_best_idx", int'(best_idx_o), 0);
    check_eq("rstmid_done", int'(done_o), 0);
    rst_i = 1'b0;
    clear_mon(4);
    repeat (20) @(negedge clk_i);
    check_eq("rstmid_no_done", n_done, 0);
    check_eq("rstmid_idle", int'(busy_o), 0);
    run_pass("after_rst", FME_BLK_H4, 4, 1'b0);
    check_eq("after_rst_best_satd", int'(best_satd_o), 60);
    check_eq("after_rst_best_idx", int'(best_idx_o), 6);

    // Spurious pulses in IDLE and a duplicate pulse after each block completes
    spur = 1'b1;
    repeat (2) @(negedge clk_i);
    spur = 1'b0;
    check_eq("spur_idle_busy", int'(busy_o), 0);
    dbl_en = 1'b1;
    run_pass("spur", FME_BLK_H4, 4, 1'b0);
    dbl_en = 1'b0;
    check_eq("spur_blk_valid", n_blk, 8);
    check_eq("spur_clr_gap_err", gap_err, 0);
    check_eq("spur_best_satd", int'(best_satd_o), 60);
    check_eq("spur_best_idx", int'(best_idx_o), 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
